// File: rtl/arithmetic_pkg.sv
// Shared opcode encodings, FSM states and the code-legality check
// for the pipelined RV ALU with the M-extension.
package arithmetic_pkg;

  typedef enum logic [2:0] {
    F3_ADD_SUB = 3'd0,
    F3_SLL     = 3'd1,
    F3_SLT     = 3'd2,
    F3_SLTU    = 3'd3,
    F3_XOR     = 3'd4,
    F3_SRL_SRA = 3'd5,
    F3_OR      = 3'd6,
    F3_AND     = 3'd7
  } funct3_e;

  typedef enum logic [2:0] {
    M_MUL    = 3'd0,
    M_MULH   = 3'd1,
    M_MULHSU = 3'd2,
    M_MULHU  = 3'd3,
    M_DIV    = 3'd4,
    M_DIVU   = 3'd5,
    M_REM    = 3'd6,
    M_REMU   = 3'd7
  } m_funct3_e;

  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

  function automatic logic code_is_legal(input logic [6:0] f7, input logic [2:0] f3,
                                         input logic en_m);
    case (f7)
      F7_BASE:   return 1'b1;
      F7_ALT:    return (f3 == F3_ADD_SUB) || (f3 == F3_SRL_SRA);
      F7_MULDIV: return en_m;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/arithmetic_muldiv.sv
// Iterative multiply/divide engine: one shift-add or restoring-subtract step
// per cycle on operand magnitudes, then a sign fix in the FIX state.
module arithmetic_muldiv
  import arithmetic_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic [XLEN-1:0] i_lhs,
  input  logic [XLEN-1:0] i_rhs,
  input  logic [2:0]      i_op,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int CW = $clog2(XLEN);

  md_state_e       r_state, w_state_next;
  m_funct3_e       r_op;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_hi, r_lo, r_b;
  logic            r_neg;

  logic            w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [XLEN-1:0] w_a_mag, w_b_mag;
  logic [XLEN:0]   w_mul_sum, w_div_shift, w_div_diff;
  logic            w_div_ge;
  logic [2*XLEN-1:0] w_prod, w_prod_fix;

  assign w_a_signed = (i_op == M_MULH) || (i_op == M_MULHSU) || (i_op == M_DIV) || (i_op == M_REM);
  assign w_b_signed = (i_op == M_MULH) || (i_op == M_DIV) || (i_op == M_REM);
  assign w_a_neg    = w_a_signed && i_lhs[XLEN-1];
  assign w_b_neg    = w_b_signed && i_rhs[XLEN-1];
  assign w_a_mag    = w_a_neg ? -i_lhs : i_lhs;
  assign w_b_mag    = w_b_neg ? -i_rhs : i_rhs;

  // r_hi accumulates the partial product / remainder, r_lo holds multiplier / quotient bits.
  assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_div_shift = {r_hi, r_lo[XLEN-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_b};
  // Partial remainder is always below r_b, so the top bit of the difference is a pure borrow.
  assign w_div_ge    = ~w_div_diff[XLEN];

  assign w_prod     = {r_hi, r_lo};
  assign w_prod_fix = r_neg ? -w_prod : w_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_state_next = ST_CALC;
      ST_CALC: if (r_cnt == CW'(XLEN - 1)) w_state_next = ST_FIX;
      ST_FIX:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op  <= M_MUL;
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_b   <= '0;
      r_neg <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_op  <= m_funct3_e'(i_op);
            r_cnt <= '0;
            r_hi  <= '0;
            r_lo  <= w_a_mag;
            r_b   <= w_b_mag;
            r_neg <= (i_op == M_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
          end
        end
        ST_CALC: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_op[2]) begin
            r_hi <= w_div_ge ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0];
            r_lo <= {r_lo[XLEN-2:0], w_div_ge};
          end else begin
            r_hi <= w_mul_sum[XLEN:1];
            r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_result = '0;
    case (r_op)
      M_MUL:                     o_result = w_prod_fix[XLEN-1:0];
      M_MULH, M_MULHSU, M_MULHU: o_result = w_prod_fix[2*XLEN-1:XLEN];
      M_DIV, M_DIVU:             o_result = r_neg ? -r_lo : r_lo;
      default:                   o_result = r_neg ? -r_hi : r_hi;
    endcase
  end

  assign o_busy = (r_state != ST_IDLE);
  assign o_done = (r_state == ST_FIX);

endmodule

// File: rtl/arithmetic_pipelined.sv
// Execute-stage ALU: single-cycle base ops and M-extension special cases,
// iterative mul/div via arithmetic_muldiv, registered result with ready/valid.
module arithmetic_pipelined
  import arithmetic_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter bit ENABLE_M       = 1'b1,
  parameter bit SHIFT_SATURATE = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lhs,
  input  logic [XLEN-1:0] rhs,
  input  logic [2:0]      operation,
  input  logic [6:0]      metadata,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [XLEN-1:0] result,
  output logic            arithmetic_code_valid,
  output logic            result_valid,
  input  logic            result_ready
);

  localparam int SW = $clog2(XLEN);

  logic [XLEN-1:0] r_result;
  logic            r_result_valid, r_code_valid;

  logic            w_accept, w_legal, w_is_m, w_div_zero, w_div_ovf, w_special, w_iterate;
  logic            w_md_busy, w_md_done, w_shift_big;
  logic [SW-1:0]   w_shamt;
  logic [XLEN-1:0] w_alu, w_load_val, w_md_result;

  assign w_legal    = code_is_legal(metadata, operation, ENABLE_M);
  assign w_is_m     = w_legal && (metadata == F7_MULDIV);
  assign w_div_zero = operation[2] && (rhs == '0);
  assign w_div_ovf  = operation[2] && !operation[0] && (rhs == '1) &&
                      (lhs == {1'b1, {(XLEN-1){1'b0}}});
  assign w_special  = w_div_zero || w_div_ovf;
  assign w_iterate  = w_is_m && !w_special;

  // rst gates in_ready so nothing is accepted while reset is held.
  assign in_ready = rst && !w_md_busy && (!r_result_valid || result_ready);
  assign w_accept = in_valid && in_ready;

  assign w_shamt     = rhs[SW-1:0];
  assign w_shift_big = SHIFT_SATURATE && (|rhs[XLEN-1:SW]);

  always_comb begin
    w_alu = '0;
    case (funct3_e'(operation))
      F3_ADD_SUB: w_alu = (metadata == F7_ALT) ? lhs - rhs : lhs + rhs;
      F3_SLL:     w_alu = w_shift_big ? '0 : lhs << w_shamt;
      F3_SLT:     w_alu = {{(XLEN-1){1'b0}}, $signed(lhs) < $signed(rhs)};
      F3_SLTU:    w_alu = {{(XLEN-1){1'b0}}, lhs < rhs};
      F3_XOR:     w_alu = lhs ^ rhs;
      F3_SRL_SRA: begin
        if (metadata == F7_ALT) w_alu = w_shift_big ? {XLEN{lhs[XLEN-1]}} : $signed(lhs) >>> w_shamt;
        else                    w_alu = w_shift_big ? '0 : lhs >> w_shamt;
      end
      F3_OR:      w_alu = lhs | rhs;
      F3_AND:     w_alu = lhs & rhs;
      default:    w_alu = '0;
    endcase
  end

  // operation[1] separates REM/REMU from DIV/DIVU in the special-case results.
  always_comb begin
    w_load_val = '0;
    if (!w_legal)        w_load_val = '0;
    else if (!w_is_m)    w_load_val = w_alu;
    else if (w_div_zero) w_load_val = operation[1] ? lhs : '1;
    else                 w_load_val = operation[1] ? '0 : lhs;
  end

  arithmetic_muldiv #(
    .XLEN(XLEN)
  ) u_muldiv (
    .clk     (clk),
    .rst_n   (rst),
    .i_start (w_accept && w_iterate),
    .i_lhs   (lhs),
    .i_rhs   (rhs),
    .i_op    (operation),
    .o_busy  (w_md_busy),
    .o_done  (w_md_done),
    .o_result(w_md_result)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_code_valid   <= 1'b0;
    end else if (w_accept && !w_iterate) begin
      r_result       <= w_load_val;
      r_result_valid <= 1'b1;
      r_code_valid   <= w_legal;
    end else if (w_md_done) begin
      r_result       <= w_md_result;
      r_result_valid <= 1'b1;
      r_code_valid   <= 1'b1;
    end else if (result_ready) begin
      r_result_valid <= 1'b0;
    end
  end

  assign result                = r_result;
  assign result_valid          = r_result_valid;
  assign arithmetic_code_valid = r_code_valid;

endmodule

// File: tb/tb_arithmetic_pipelined.sv
// Directed-vector bench for arithmetic_pipelined: a default instance plus
// ENABLE_M=0 and SHIFT_SATURATE=0 variants sharing the operand buses.
module tb_arithmetic_pipelined;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] lhs = '0, rhs = '0;
  logic [2:0]  operation = '0;
  logic [6:0]  metadata = '0;
  logic        iv_a = 1'b0, iv_b = 1'b0, iv_c = 1'b0;
  logic        rr_a = 1'b1, rr_bc = 1'b1;
  logic        ir_a, ir_b, ir_c, cv_a, cv_b, cv_c, rv_a, rv_b, rv_c;
  logic [31:0] res_a, res_b, res_c;

  always #5 clk = ~clk;

  arithmetic_pipelined #(.XLEN(32), .ENABLE_M(1'b1), .SHIFT_SATURATE(1'b1)) u_dut (
    .clk(clk), .rst(rst), .lhs(lhs), .rhs(rhs), .operation(operation), .metadata(metadata),
    .in_valid(iv_a), .in_ready(ir_a), .result(res_a), .arithmetic_code_valid(cv_a),
    .result_valid(rv_a), .result_ready(rr_a));

  arithmetic_pipelined #(.XLEN(32), .ENABLE_M(1'b0), .SHIFT_SATURATE(1'b1)) u_nom (
    .clk(clk), .rst(rst), .lhs(lhs), .rhs(rhs), .operation(operation), .metadata(metadata),
    .in_valid(iv_b), .in_ready(ir_b), .result(res_b), .arithmetic_code_valid(cv_b),
    .result_valid(rv_b), .result_ready(rr_bc));

  arithmetic_pipelined #(.XLEN(32), .ENABLE_M(1'b1), .SHIFT_SATURATE(1'b0)) u_nosat (
    .clk(clk), .rst(rst), .lhs(lhs), .rhs(rhs), .operation(operation), .metadata(metadata),
    .in_valid(iv_c), .in_ready(ir_c), .result(res_c), .arithmetic_code_valid(cv_c),
    .result_valid(rv_c), .result_ready(rr_bc));

  int          sel = 0;
  logic        cur_ready, cur_cv, cur_rv;
  logic [31:0] cur_res;

  always_comb begin
    cur_ready = ir_a; cur_cv = cv_a; cur_rv = rv_a; cur_res = res_a;
    case (sel)
      1: begin cur_ready = ir_b; cur_cv = cv_b; cur_rv = rv_b; cur_res = res_b; end
      2: begin cur_ready = ir_c; cur_cv = cv_c; cur_rv = rv_c; cur_res = res_c; end
      default: ;
    endcase
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // edges = clock edges after the acceptance edge before result_valid is seen high.
  typedef struct {
    string       name;
    int          inst;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        cv;
    int          edges;
  } vec_t;

  function automatic vec_t mk(input string name, input int inst, input logic [6:0] f7,
                              input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp, input logic cv, input int edges);
    vec_t v;
    v.name = name; v.inst = inst; v.f7 = f7; v.f3 = f3; v.a = a; v.b = b;
    v.exp = exp; v.cv = cv; v.edges = edges;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    int lat;
    @(negedge clk);
    sel = v.inst; lhs = v.a; rhs = v.b; operation = v.f3; metadata = v.f7;
    iv_a = (v.inst == 0); iv_b = (v.inst == 1); iv_c = (v.inst == 2);
    #1;
    check({v.name, " in_ready"}, {31'd0, cur_ready}, 32'd1);
    @(posedge clk); #1;
    iv_a = 1'b0; iv_b = 1'b0; iv_c = 1'b0;
    lat = 0;
    while (!cur_rv && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({v.name, " latency"}, 32'(lat), 32'(v.edges));
    check({v.name, " result"}, cur_res, v.exp);
    check({v.name, " code_valid"}, {31'd0, cur_cv}, {31'd0, v.cv});
    $display("vec %-12s inst=%0d f7=%02h f3=%0d a=%08h b=%08h -> res=%08h cv=%0b edges=%0d",
             v.name, v.inst, v.f7, v.f3, v.a, v.b, cur_res, cur_cv, lat);
  endtask

  vec_t vt[$];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen;

    vt.push_back(mk("add",       0, 7'h00, 3'd0, 32'h0000_0001, 32'h0000_ffff, 32'h0001_0000, 1'b1, 0));
    vt.push_back(mk("sub",       0, 7'h20, 3'd0, 32'h0000_0000, 32'h0000_0001, 32'hffff_ffff, 1'b1, 0));
    vt.push_back(mk("slt",       0, 7'h00, 3'd2, 32'hffff_ffff, 32'h0000_0001, 32'h0000_0001, 1'b1, 0));
    vt.push_back(mk("sltu",      0, 7'h00, 3'd3, 32'hffff_ffff, 32'h0000_0001, 32'h0000_0000, 1'b1, 0));
    vt.push_back(mk("sra_sat",   0, 7'h20, 3'd5, 32'ha863_201f, 32'h0000_0020, 32'hffff_ffff, 1'b1, 0));
    vt.push_back(mk("sll_sat",   0, 7'h00, 3'd1, 32'h0000_0001, 32'h0000_0021, 32'h0000_0000, 1'b1, 0));
    vt.push_back(mk("srl",       0, 7'h00, 3'd5, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b1, 0));
    vt.push_back(mk("and",       0, 7'h00, 3'd7, 32'hf0f0_f0f0, 32'hff00_ff00, 32'hf000_f000, 1'b1, 0));
    vt.push_back(mk("mul",       0, 7'h01, 3'd0, 32'h0000_0007, 32'hffff_fffd, 32'hffff_ffeb, 1'b1, 33));
    vt.push_back(mk("mulh",      0, 7'h01, 3'd1, 32'hffff_fffd, 32'h0000_0007, 32'hffff_ffff, 1'b1, 33));
    vt.push_back(mk("mulhsu",    0, 7'h01, 3'd2, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_ffff, 1'b1, 33));
    vt.push_back(mk("mulhu",     0, 7'h01, 3'd3, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_fffe, 1'b1, 33));
    vt.push_back(mk("div",       0, 7'h01, 3'd4, 32'hffff_fff9, 32'h0000_0002, 32'hffff_fffd, 1'b1, 33));
    vt.push_back(mk("rem",       0, 7'h01, 3'd6, 32'hffff_fff9, 32'h0000_0002, 32'hffff_ffff, 1'b1, 33));
    vt.push_back(mk("div_nd",    0, 7'h01, 3'd4, 32'h0000_0007, 32'hffff_fffe, 32'hffff_fffd, 1'b1, 33));
    vt.push_back(mk("rem_nd",    0, 7'h01, 3'd6, 32'h0000_0007, 32'hffff_fffe, 32'h0000_0001, 1'b1, 33));
    vt.push_back(mk("divu",      0, 7'h01, 3'd5, 32'd100,       32'd7,         32'd14,        1'b1, 33));
    vt.push_back(mk("remu",      0, 7'h01, 3'd7, 32'd100,       32'd7,         32'd2,         1'b1, 33));
    vt.push_back(mk("divu_z",    0, 7'h01, 3'd5, 32'd5,         32'd0,         32'hffff_ffff, 1'b1, 0));
    vt.push_back(mk("rem_z",     0, 7'h01, 3'd6, 32'd5,         32'd0,         32'd5,         1'b1, 0));
    vt.push_back(mk("div_ovf",   0, 7'h01, 3'd4, 32'h8000_0000, 32'hffff_ffff, 32'h8000_0000, 1'b1, 0));
    vt.push_back(mk("rem_ovf",   0, 7'h01, 3'd6, 32'h8000_0000, 32'hffff_ffff, 32'h0000_0000, 1'b1, 0));
    vt.push_back(mk("ill_f20_7", 0, 7'h20, 3'd7, 32'h1234_5678, 32'h0000_00ff, 32'h0000_0000, 1'b0, 0));
    vt.push_back(mk("ill_f7f",   0, 7'h7f, 3'd0, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b0, 0));
    vt.push_back(mk("nom_mul",   1, 7'h01, 3'd0, 32'h0000_0007, 32'hffff_fffd, 32'h0000_0000, 1'b0, 0));
    vt.push_back(mk("nom_add",   1, 7'h00, 3'd0, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b1, 0));
    vt.push_back(mk("nosat_sra", 2, 7'h20, 3'd5, 32'ha863_201f, 32'h0000_0020, 32'ha863_201f, 1'b1, 0));
    vt.push_back(mk("nosat_sll", 2, 7'h00, 3'd1, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b1, 0));

    // Reset values
    #2 rst = 1'b0;
    #10;
    check("rst result", res_a, 32'd0);
    check("rst result_valid", {31'd0, rv_a}, 32'd0);
    check("rst code_valid", {31'd0, cv_a}, 32'd0);
    check("rst in_ready", {31'd0, ir_a}, 32'd0);
    @(negedge clk) rst = 1'b1;
    #1 check("post-rst in_ready", {31'd0, ir_a}, 32'd1);

    // Back-to-back single-cycle ops
    @(negedge clk);
    lhs = 32'h0000_0001; rhs = 32'h0000_ffff; operation = 3'd0; metadata = 7'h00; iv_a = 1'b1;
    #1 check("b2b add in_ready", {31'd0, ir_a}, 32'd1);
    @(posedge clk); #1;
    check("b2b add result", res_a, 32'h0001_0000);
    check("b2b add valid", {31'd0, rv_a}, 32'd1);
    @(negedge clk);
    lhs = 32'h0; rhs = 32'h1; metadata = 7'h20;
    #1 check("b2b sub in_ready", {31'd0, ir_a}, 32'd1);
    @(posedge clk); #1;
    iv_a = 1'b0;
    check("b2b sub result", res_a, 32'hffff_ffff);
    check("b2b sub valid", {31'd0, rv_a}, 32'd1);
    $display("seq b2b add/sub -> res=%08h", res_a);
    @(posedge clk); #1;
    check("b2b valid clears", {31'd0, rv_a}, 32'd0);

    // Backpressure
    @(negedge clk);
    rr_a = 1'b0;
    lhs = 32'h1111_ffff; rhs = 32'h0204_f0f0; operation = 3'd4; metadata = 7'h00; iv_a = 1'b1;
    @(posedge clk); #1;
    lhs = 32'd2; rhs = 32'd3; operation = 3'd0;
    for (int i = 0; i < 3; i++) begin
      check("bp result hold", res_a, 32'h1315_0f0f);
      check("bp valid hold", {31'd0, rv_a}, 32'd1);
      check("bp in_ready low", {31'd0, ir_a}, 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk) rr_a = 1'b1;
    #1 check("bp release in_ready", {31'd0, ir_a}, 32'd1);
    @(posedge clk); #1;
    iv_a = 1'b0;
    check("bp second result", res_a, 32'd5);
    check("bp second valid", {31'd0, rv_a}, 32'd1);
    $display("seq backpressure xor then add -> res=%08h", res_a);
    @(posedge clk); #1;
    check("bp valid clears", {31'd0, rv_a}, 32'd0);

    // Directed table
    foreach (vt[i]) apply(vt[i]);
    sel = 0;

    // Reset in the middle of an iterative op
    @(negedge clk);
    lhs = 32'd7; rhs = 32'hffff_fffd; operation = 3'd0; metadata = 7'h01; iv_a = 1'b1;
    @(posedge clk); #1;
    iv_a = 1'b0;
    repeat (5) @(posedge clk);
    #1 check("calc busy in_ready", {31'd0, ir_a}, 32'd0);
    @(negedge clk) rst = 1'b0;
    #1;
    check("mid-rst valid", {31'd0, rv_a}, 32'd0);
    check("mid-rst in_ready", {31'd0, ir_a}, 32'd0);
    @(negedge clk) rst = 1'b1;
    #1 check("after-rst in_ready", {31'd0, ir_a}, 32'd1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (rv_a) seen = 1'b1;
    end
    check("no stale result", {31'd0, seen}, 32'd0);
    $display("seq reset mid-calc -> stale=%0b", seen);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
